// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT/FFT butterfly sequencer.
package fht_pkg;

    localparam int unsigned FHT_LW         = 4;                  // width of a log2-length field
    localparam int unsigned FHT_A_BIT_DEF  = 10;                 // default log2 of maximum point count
    localparam int unsigned FHT_MIN_LOG2N  = 2;                  // default smallest accepted log2 length
    localparam int unsigned FHT_COEF_W_DEF = FHT_A_BIT_DEF - 1;  // twiddle table holds N_MAX/2 entries

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    // Silently clamp a requested log2 length into the supported range.
    function automatic logic [FHT_LW-1:0] clamp_log2n(input logic [FHT_LW-1:0] v,
                                                      input logic [FHT_LW-1:0] lo,
                                                      input logic [FHT_LW-1:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/fht_wr_delay.sv
// Stallable DEPTH-deep delay line carrying {valid, addr_a, addr_b} from read issue to write.
module fht_wr_delay #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 3
) (
    input  logic         iCLK,
    input  logic         iRESET,
    input  logic         stall_i,
    input  logic         vld_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         vld_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [DEPTH-1:0] v_q;
    logic [W-1:0]     a_q [DEPTH];
    logic [W-1:0]     b_q [DEPTH];

    // Shift one stage per unstalled cycle; a stall freezes every stage.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (!stall_i) begin
            v_q[0] <= vld_i;
            a_q[0] <= a_i;
            b_q[0] <= b_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign vld_o = v_q[DEPTH-1];
    assign a_o   = a_q[DEPTH-1];
    assign b_o   = b_q[DEPTH-1];

endmodule

// File: rtl/fht_seq_ctrl.sv
// Radix-2 DIF butterfly sequencer: read/coef address generation, ping-pong bank
// select and delayed write-address replay. Optional macro FHT_CTRL_HALF_RATE_EN
// spreads each butterfly over two cycles (read strobe on phase 0 only).
module fht_seq_ctrl
    import fht_pkg::*;
#(
    parameter int unsigned A_BIT     = FHT_A_BIT_DEF,
    parameter int unsigned LAT       = 3,
    parameter int unsigned MIN_LOG2N = FHT_MIN_LOG2N
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic [3:0]         iLOG2N,
    input  logic               iSTALL,
    output logic               oRDY,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [3:0]         oSTAGE,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic               oRD_EN,
    output logic [A_BIT-1:0]   oADDR_RD_A,
    output logic [A_BIT-1:0]   oADDR_RD_B,
    output logic [A_BIT-2:0]   oADDR_COEF,
    output logic               oSOURCE,
    output logic               oWE,
    output logic [A_BIT-1:0]   oADDR_WR_A,
    output logic [A_BIT-1:0]   oADDR_WR_B
);

    localparam int unsigned COEF_W = A_BIT - 1;
    localparam int unsigned DCW    = $clog2(LAT + 1);

    fht_state_e        state_q, state_d;
    logic [A_BIT-1:0]  b_q, b_d;
    logic [FHT_LW-1:0] s_q, s_d, l_q, l_d;
    logic [DCW-1:0]    dc_q, dc_d;
    logic              src_q, src_d;
`ifdef FHT_CTRL_HALF_RATE_EN
    logic              ph_q, ph_d;
`endif

    logic              rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
    logic              stz_q, stz_d, stl_q, stl_d;
    logic [A_BIT-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [COEF_W-1:0] coef_q, coef_d;

    logic [A_BIT-1:0]  last_b_c, half_c, pos_c, grp_c, ga_c, coef_full_c;
    logic [FHT_LW-1:0] sh_c;
    logic              wr_vld_c;

    assign last_b_c = (A_BIT'(1) << (l_q - FHT_LW'(1))) - A_BIT'(1);

    // Next state, counters and registered status outputs.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        l_d     = l_q;
        dc_d    = dc_q;
        src_d   = src_q;
`ifdef FHT_CTRL_HALF_RATE_EN
        ph_d    = ph_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    l_d     = clamp_log2n(iLOG2N, FHT_LW'(MIN_LOG2N), FHT_LW'(A_BIT));
                    b_d     = '0;
                    s_d     = '0;
                    src_d   = 1'b0;
`ifdef FHT_CTRL_HALF_RATE_EN
                    ph_d    = 1'b0;
`endif
                end
            end
            ST_RUN: begin
`ifdef FHT_CTRL_HALF_RATE_EN
                ph_d = ~ph_q;
                if (ph_q) begin
`endif
                    if (b_q == last_b_c) begin
                        state_d = ST_DRAIN;
                        b_d     = '0;
                        dc_d    = '0;
                    end else begin
                        b_d = b_q + A_BIT'(1);
                    end
`ifdef FHT_CTRL_HALF_RATE_EN
                end
`endif
            end
            ST_DRAIN: begin
                if (dc_q == DCW'(LAT - 1)) begin
                    dc_d = '0;
                    if (s_q == l_q - FHT_LW'(1)) begin
                        state_d = ST_DONE;
                        src_d   = l_q[0];          // bank that holds the result
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + FHT_LW'(1);
                        src_d   = ~src_q;
                        b_d     = '0;
                    end
                end else begin
                    dc_d = dc_q + DCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
`ifdef FHT_CTRL_HALF_RATE_EN
        rd_en_d = (state_d == ST_RUN) && !ph_d;
`else
        rd_en_d = (state_d == ST_RUN);
`endif
        stz_d = busy_d && (s_d == '0);
        stl_d = busy_d && (s_d == l_d - FHT_LW'(1));
    end

    // DIF butterfly address arithmetic for the upcoming (b, s, L).
    always_comb begin
        sh_c        = l_d - s_d - FHT_LW'(1);
        half_c      = A_BIT'(1) << sh_c;
        pos_c       = b_d & (half_c - A_BIT'(1));
        grp_c       = b_d >> sh_c;
        ga_c        = (grp_c << (sh_c + FHT_LW'(1))) | pos_c;
        coef_full_c = (pos_c << s_d) << (FHT_LW'(A_BIT) - l_d);
    end

    // Address outputs: load in RUN, hold through DRAIN/DONE, clear in IDLE.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        coef_d = coef_q;
        if (state_d == ST_RUN) begin
            rd_a_d = ga_c;
            rd_b_d = ga_c | half_c;
            coef_d = COEF_W'(coef_full_c);
        end else if (state_d == ST_IDLE) begin
            rd_a_d = '0;
            rd_b_d = '0;
            coef_d = '0;
        end
    end

    // State and output registers; a stall freezes everything.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            s_q     <= '0;
            l_q     <= FHT_LW'(MIN_LOG2N);
            dc_q    <= '0;
            src_q   <= 1'b0;
`ifdef FHT_CTRL_HALF_RATE_EN
            ph_q    <= 1'b0;
`endif
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            stz_q   <= 1'b0;
            stl_q   <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            coef_q  <= '0;
        end else if (!iSTALL) begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            l_q     <= l_d;
            dc_q    <= dc_d;
            src_q   <= src_d;
`ifdef FHT_CTRL_HALF_RATE_EN
            ph_q    <= ph_d;
`endif
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            stz_q   <= stz_d;
            stl_q   <= stl_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            coef_q  <= coef_d;
        end
    end

    fht_wr_delay #(
        .W     (A_BIT),
        .DEPTH (LAT)
    ) u_wr_delay (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .stall_i (iSTALL),
        .vld_i   (rd_en_q),
        .a_i     (rd_a_q),
        .b_i     (rd_b_q),
        .vld_o   (wr_vld_c),
        .a_o     (oADDR_WR_A),
        .b_o     (oADDR_WR_B)
    );

    // Strobes are masked in the stalled cycle itself so a held op is not consumed twice.
    assign oRD_EN     = rd_en_q  & ~iSTALL;
    assign oWE        = wr_vld_c & ~iSTALL;
    assign oDONE      = done_q   & ~iSTALL;
    assign oRDY       = rdy_q;
    assign oBUSY      = busy_q;
    assign oSTAGE     = s_q;
    assign oST_ZERO   = stz_q;
    assign oST_LAST   = stl_q;
    assign oSOURCE    = src_q;
    assign oADDR_RD_A = rd_a_q;
    assign oADDR_RD_B = rd_b_q;
    assign oADDR_COEF = coef_q;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// Scoreboard bench for fht_seq_ctrl (A_BIT=4, LAT=3).
module tb_fht_seq_ctrl;

    localparam int unsigned A_BIT = 4;
    localparam int unsigned LAT   = 3;
`ifdef FHT_CTRL_HALF_RATE_EN
    localparam int R = 2, STALL_AT = 14, RST_AT = 16;
`else
    localparam int R = 1, STALL_AT = 9,  RST_AT = 10;
`endif

    logic             iCLK, iRESET, iSTART, iSTALL;
    logic [3:0]       iLOG2N;
    logic             oRDY, oBUSY, oDONE, oST_ZERO, oST_LAST, oRD_EN, oSOURCE, oWE;
    logic [3:0]       oSTAGE;
    logic [A_BIT-1:0] oADDR_RD_A, oADDR_RD_B, oADDR_WR_A, oADDR_WR_B;
    logic [A_BIT-2:0] oADDR_COEF;

    fht_seq_ctrl #(.A_BIT(A_BIT), .LAT(LAT), .MIN_LOG2N(2)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iLOG2N(iLOG2N), .iSTALL(iSTALL),
        .oRDY(oRDY), .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE),
        .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .oRD_EN(oRD_EN),
        .oADDR_RD_A(oADDR_RD_A), .oADDR_RD_B(oADDR_RD_B), .oADDR_COEF(oADDR_COEF),
        .oSOURCE(oSOURCE), .oWE(oWE), .oADDR_WR_A(oADDR_WR_A), .oADDR_WR_B(oADDR_WR_B)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct { int a; int b; int c; int s; } op_t;

    op_t rd_q[$];
    op_t wr_q[$];
    int  lat_q[$];
    op_t me, mw;
    int  errs = 0, checks = 0;
    int  cyc = 0, act_cyc = 0, cur_l = 3;

    // Hand-computed L=3 sequence: (rd_a, rd_b, coef) per butterfly, stages 0..2.
    int tbl_a [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int tbl_b [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int tbl_c [12] = '{0,2,4,6, 0,4,0,4, 0,0,0,0};

    always @(posedge iCLK) begin
        cyc <= cyc + 1;
        if (!iSTALL) act_cyc <= act_cyc + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected butterflies: explicit tables for L=3, group/position enumeration otherwise.
    task automatic push_expected(input int l);
        op_t e;
        int  n, half;
        cur_l = l;
        n = 1 << l;
        if (l == 3) begin
            for (int i = 0; i < 12; i++) begin
                e.a = tbl_a[i]; e.b = tbl_b[i]; e.c = tbl_c[i]; e.s = i / 4;
                rd_q.push_back(e); wr_q.push_back(e);
            end
        end else begin
            for (int s = 0; s < l; s++) begin
                half = n >> (s + 1);
                for (int g = 0; g < (1 << s); g++)
                    for (int p = 0; p < half; p++) begin
                        e.a = g * 2 * half + p;
                        e.b = e.a + half;
                        e.c = ((p << s) * (16 >> l)) % 8;
                        e.s = s;
                        rd_q.push_back(e); wr_q.push_back(e);
                    end
            end
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a read or a write.
    always @(negedge iCLK) begin
        if (iRESET) begin
            if (oRD_EN) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    me = rd_q.pop_front();
                    chk("rd_a", int'(oADDR_RD_A), me.a);
                    chk("rd_b", int'(oADDR_RD_B), me.b);
                    chk("coef", int'(oADDR_COEF), me.c);
                    chk("stage", int'(oSTAGE), me.s);
                    chk("source", int'(oSOURCE), me.s % 2);
                    chk("st_zero", int'(oST_ZERO), int'(me.s == 0));
                    chk("st_last", int'(oST_LAST), int'(me.s == cur_l - 1));
                    chk("busy_run", int'(oBUSY), 1);
                    if (wr_q.size() > 0) chk("prior_stage_write_pending", int'(wr_q[0].s < me.s), 0);
                    lat_q.push_back(act_cyc);
                end
            end
            if (oWE) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_a", int'(oADDR_WR_A), mw.a);
                    chk("wr_b", int'(oADDR_WR_B), mw.b);
                    if (lat_q.size() == 0) chk("wr_without_read", 1, 0);
                    else chk("wr_latency", act_cyc - lat_q.pop_front(), int'(LAT));
                end
            end
        end
    end

    // One transform: optional start pulse while busy, stall window, or reset abort.
    task automatic run(input logic [3:0] l_in, input int exp_l, input int pulse_at,
                       input int stall_at, input int stall_len, input int fa, input int fb,
                       input int rst_at);
        int t0, exp_done;
        bit done, aborted;
        push_expected(exp_l);
        exp_done = exp_l * (R * (1 << exp_l) / 2 + int'(LAT)) + 1 + stall_len;
        @(posedge iCLK); #1;
        iLOG2N = l_in; iSTART = 1'b1; t0 = cyc;
        done = 0; aborted = 0;
        for (int k = 1; k <= 300 && !done && !aborted; k++) begin
            @(posedge iCLK); #1;
            iSTART = (k == pulse_at);
            iSTALL = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
            if (k == rst_at) iRESET = 1'b0;
            @(negedge iCLK);
            if (k == rst_at) begin
                aborted = 1;
                chk("abort_rdy", int'(oRDY), 1);
                chk("abort_busy", int'(oBUSY), 0);
                chk("abort_rd_en", int'(oRD_EN), 0);
                chk("abort_addr", int'({oADDR_RD_A, oADDR_RD_B, oADDR_COEF, oADDR_WR_A, oADDR_WR_B}), 0);
                chk("abort_misc", int'({oSTAGE, oSOURCE, oWE, oDONE, oST_ZERO, oST_LAST}), 0);
                rd_q.delete(); wr_q.delete(); lat_q.delete();
                @(posedge iCLK); #1; iRESET = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge iCLK);
                    chk("abort_no_done", int'(oDONE), 0);
                end
                chk("abort_idle_rdy", int'(oRDY), 1);
            end else begin
                if (iSTALL) begin
                    chk("stall_rd_en", int'(oRD_EN), 0);
                    chk("stall_we", int'(oWE), 0);
                    chk("stall_hold_a", int'(oADDR_RD_A), fa);
                    chk("stall_hold_b", int'(oADDR_RD_B), fb);
                end
                if (oDONE) begin
                    done = 1;
                    chk("done_cycle", cyc - t0, exp_done);
                end
            end
        end
        iSTART = 1'b0; iSTALL = 1'b0;
        if (!aborted) begin
            if (!done) chk("done_timeout", 0, 1);
            @(posedge iCLK); #1;
            @(negedge iCLK);
            chk("done_one_pulse", int'(oDONE), 0);
            chk("idle_rdy", int'(oRDY), 1);
            chk("idle_busy", int'(oBUSY), 0);
            chk("idle_source", int'(oSOURCE), exp_l % 2);
            chk("idle_stage", int'(oSTAGE), 0);
            chk("rd_queue_drained", rd_q.size(), 0);
            chk("wr_queue_drained", wr_q.size(), 0);
        end
    endtask

    initial begin
        iRESET = 1'b0; iSTART = 1'b0; iSTALL = 1'b0; iLOG2N = 4'd0;
        repeat (2) @(negedge iCLK);
        chk("reset_rdy", int'(oRDY), 1);
        chk("reset_outputs", int'({oBUSY, oDONE, oSTAGE, oST_ZERO, oST_LAST, oRD_EN, oSOURCE, oWE}), 0);
        chk("reset_addr", int'({oADDR_RD_A, oADDR_RD_B, oADDR_COEF, oADDR_WR_A, oADDR_WR_B}), 0);
        @(posedge iCLK); #1; iRESET = 1'b1;

        run(4'd3,  3, 3, 0, 0, 0, 0, 0);          // nominal L=3, start pulse during RUN
        run(4'd15, 4, 0, 0, 0, 0, 0, 0);          // clamped up-range
        run(4'd0,  2, 0, 0, 0, 0, 0, 0);          // clamped down-range
        run(4'd3,  3, 0, STALL_AT, 5, 1, 3, 0);   // 5-cycle stall mid stage 1
        run(4'd3,  3, 0, 0, 0, 0, 0, RST_AT);     // reset abort mid stage 1
        run(4'd3,  3, 0, 0, 0, 0, 0, 0);          // clean restart

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
